clk_div_8k: RTL and testbench
=============================

# clk_div_8k

Fixed-ratio clock divider that derives a 50 % duty-cycle `newclk` from the system clock by toggling every HALF_PERIOD input cycles. With the default HALF_PERIOD = 100, the output frequency is f_clk / 200; for example, a 1.6 MHz system clock gives an 8 kHz output. The block feeds downstream logic that needs an 8 kHz sample or tick clock. It has no enable; it runs whenever reset is deasserted.

## Interface
Parameters:
- HALF_PERIOD, 100: number of `clk` rising edges per `newclk` half-period. Must be ≥ 1.
- CNT_W, $clog2(HALF_PERIOD), minimum 1: counter width. Default value is 7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low; `rst` = 0 clears all state immediately.
- newclk  output  1  divided clock, driven directly from a register (glitch-free).

## Operation
- Internal state:
  - `count`, CNT_W bits, range 0..HALF_PERIOD-1.
  - `newclk` register.
- Reset (`rst` = 0, asynchronous): `count` = 0 and `newclk` = 0 immediately, without waiting for a clock edge. Both hold while reset is low.
- Each `clk` rising edge with `rst` = 1:
  - If `count` == HALF_PERIOD-1: `count` ← 0 and `newclk` ← ~`newclk`.
  - Otherwise: `count` ← `count` + 1 and `newclk` holds.
- `count` never exceeds HALF_PERIOD-1 and never wraps through the full CNT_W range; the wrap happens only at the terminal compare.
- HALF_PERIOD = 1 degenerates to `newclk` toggling every edge (f_clk/2).
- No other inputs; behaviour is fully deterministic from reset release.

## Timing
- Reset release: the first `clk` rising edge with `rst` = 1 counts as edge 1 (`count` 0→1).
- Toggle schedule, counting rising edges after reset release:
  - Edge HALF_PERIOD (edge 100): `newclk` goes 0→1.
  - Edge 2·HALF_PERIOD (edge 200): `newclk` goes 1→0.
  - Edge 3·HALF_PERIOD (edge 300): `newclk` goes 0→1.
  - The pattern repeats with period 2·HALF_PERIOD.
- `newclk` changes only on `clk` rising edges, except for the asynchronous clear to 0.
- Duty cycle is exactly 50 % (HALF_PERIOD high, HALF_PERIOD low).
- Reset mid-operation: `newclk` forces to 0 within the same delta or asynchronous path regardless of phase, even if it was 1. After release, the schedule restarts from edge 1.
- Reset released coincident with a `clk` edge: that edge does not count. Counting starts at the next edge.

## Test plan
- Power-on reset: `rst` = 0 for 4 `clk` cycles, then check `newclk` = 0 and `count` = 0.
- Hold in reset: keep `rst` = 0 for an additional 200 cycles, then check `newclk` stays 0 throughout.
- Normal operation:
  - Release reset and sample `newclk` just after the stated edge: edge 99 → 0; edge 100 → 1; edge 199 → 1; edge 200 → 0; edge 300 → 1.
- Period and duty check: over 1000 cycles, check every high and low interval is exactly 100 `clk` cycles.
- Mid-operation reset:
  - While `newclk` = 1, at about edge 115, drive `rst` = 0 asynchronously between edges.
  - Check `newclk` = 0 before the next edge.
  - Release reset and check the first 0→1 transition occurs at edge 100 after release.
- Parameter override: with HALF_PERIOD = 3, check `newclk` toggles at edges 3, 6, 9 after release.

Source files
------------

// File: rtl/clk_div_8k_if.sv
// clk_div_8k_if: divided-clock output bundle
interface clk_div_8k_if;
    logic newclk;
    modport master(output newclk);
    modport slave(input newclk);
endinterface

// File: rtl/clk_div_8k.sv
// clk_div_8k: 50% duty divider, newclk toggles every HALF_PERIOD clk rising edges
module clk_div_8k #(
    parameter int HALF_PERIOD = 100,
    parameter int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1
) (
    input logic clk,
    input logic rst,
    clk_div_8k_if.master div
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);
    logic [CNT_W-1:0] count;
    logic newclk;
    // Wrap only at the terminal compare so non-power-of-two ratios stay exact
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            count <= '0;
            newclk <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            newclk <= ~newclk;
        end else begin
            count <= count + 1'b1;
        end
    assign div.newclk = newclk;
endmodule

// File: tb/tb_clk_div_8k.sv
// tb_clk_div_8k: directed checks of reset, toggle schedule, duty and HALF_PERIOD=3 override
module tb_clk_div_8k;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int e = 0;
    clk_div_8k_if ifa();
    clk_div_8k_if ifb();
    clk_div_8k dut (.clk(clk), .rst(rst), .div(ifa));
    clk_div_8k #(.HALF_PERIOD(3)) dut3 (.clk(clk), .rst(rst), .div(ifb));
    always #5 clk = ~clk;
    typedef struct {
        int edge_n;
        logic exp;
    } vec_t;
    vec_t vecs[5];
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        e++;
        #1;
    endtask
    initial begin
        int last;
        int ntog;
        int first;
        logic prev;
        logic stuck;
        vecs[0] = '{99, 1'b0};
        vecs[1] = '{100, 1'b1};
        vecs[2] = '{199, 1'b1};
        vecs[3] = '{200, 1'b0};
        vecs[4] = '{300, 1'b1};
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("por_newclk", int'(ifa.newclk), 0);
        chk("por_count", int'(dut.count), 0);
        chk("por_newclk3", int'(ifb.newclk), 0);
        stuck = 1'b0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (ifa.newclk !== 1'b0 || ifb.newclk !== 1'b0) stuck = 1'b1;
        end
        chk("hold_reset_low", int'(stuck), 0);
        @(negedge clk);
        rst = 1'b1;
        e = 0;
        // HALF_PERIOD=3 instance: toggles at edges 3, 6, 9
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("hp3_edge%0d", e), int'(ifb.newclk), (e / 3) % 2);
        end
        for (int i = 0; i < 5; i++) begin
            while (e < vecs[i].edge_n) tick();
            chk($sformatf("edge%0d", e), int'(ifa.newclk), int'(vecs[i].exp));
        end
        last = 300;
        ntog = 0;
        prev = ifa.newclk;
        while (e < 1300) begin
            tick();
            if (ifa.newclk !== prev) begin
                chk($sformatf("interval_at%0d", e), e - last, 100);
                last = e;
                ntog++;
                prev = ifa.newclk;
            end
        end
        chk("toggle_count", ntog, 10);
        while (e < 1315) tick();
        chk("pre_reset_high", int'(ifa.newclk), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_clear_newclk", int'(ifa.newclk), 0);
        chk("async_clear_count", int'(dut.count), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        e = 0;
        first = -1;
        while (e < 150 && first < 0) begin
            tick();
            if (ifa.newclk === 1'b1) first = e;
        end
        chk("restart_first_rise", first, 100);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
